line_bus_ctrl: RTL and testbench

- Shared memory-bus controller between the instruction cache and the data cache of one hart.
- Arbitrates whole-line transactions: icache line fill, dcache line fill, dcache write-back.
- Serialises each 1024-bit cache line into 64-bit beats on a narrow memory port and reassembles read beats into a full line.
- Returns each completed line to the granted cache with a one-cycle data-valid pulse.

---
 rtl/line_bus_ctrl_if.sv | 38 +++
 rtl/line_bus_ctrl.sv | 118 +++++++++++
 tb/tb_line_bus_ctrl.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/line_bus_ctrl_if.sv
// Bundle of cache-side and memory-side signals of the line bus controller.
// The master view belongs to the controller; the slave view is seen by the
// caches and the memory that sit around it.
interface line_bus_ctrl_if #(
  parameter int ADDR_W = 64,
  parameter int LINE_W = 1024,
  parameter int BEAT_W = 64
);
  // instruction cache side
  logic              ic_rd;
  logic [ADDR_W-1:0] ic_addr;
  logic [LINE_W-1:0] ic_data;
  logic              ic_dv;
  // data cache side
  logic              dc_rd;
  logic              dc_wr;
  logic [ADDR_W-1:0] dc_addr;
  logic [LINE_W-1:0] dc_wdata;
  logic [LINE_W-1:0] dc_data;
  logic              dc_dv;
  // narrow memory port
  logic              m_req;
  logic              m_we;
  logic [ADDR_W-1:0] m_addr;
  logic [BEAT_W-1:0] m_wdata;
  logic [BEAT_W-1:0] m_rdata;
  logic              m_ack;

  modport master (
    input  ic_rd, ic_addr, dc_rd, dc_wr, dc_addr, dc_wdata, m_rdata, m_ack,
    output ic_data, ic_dv, dc_data, dc_dv, m_req, m_we, m_addr, m_wdata
  );

  modport slave (
    output ic_rd, ic_addr, dc_rd, dc_wr, dc_addr, dc_wdata, m_rdata, m_ack,
    input  ic_data, ic_dv, dc_data, dc_dv, m_req, m_we, m_addr, m_wdata
  );
endinterface

// File: rtl/line_bus_ctrl.sv
// Shared line bus controller for the icache and dcache of one hart.
// Arbitrates whole-line fills and write-backs, splits each line into
// 64-bit beats on the memory port and reassembles read beats into a line.
module line_bus_ctrl #(
  parameter int ADDR_W = 64,
  parameter int LINE_W = 1024,
  parameter int BEAT_W = 64
) (
  input  logic          clk,
  input  logic          clr_n,
  line_bus_ctrl_if.master bus
);

  // 16 beats per line; the 4-bit beat counter relies on this ratio
  localparam int BEATS = LINE_W / BEAT_W;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_XFER = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic OWN_IC = 1'b0;
  localparam logic OWN_DC = 1'b1;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q;
  logic [LINE_W-1:0] line_q;
  logic [ADDR_W-1:7] addr_q;
  logic              we_q;
  logic              owner_q;
  logic              last_q;

  logic ic_req;
  logic dc_req;
  logic win_dc;
  logic win_we;
  logic grant;
  logic beat_ack;

  // low line-offset bits of the request addresses are ignored by design
  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.ic_addr[6:0], bus.dc_addr[6:0]};

  // round-robin pick: a lone requester wins, otherwise the one not served last
  always_comb begin
    ic_req   = bus.ic_rd;
    dc_req   = bus.dc_rd | bus.dc_wr;
    win_dc   = dc_req & (~ic_req | (last_q == OWN_IC));
    win_we   = win_dc & bus.dc_wr;   // write-back beats a pending dcache read
    grant    = (state_q == S_IDLE) & (ic_req | dc_req);
    beat_ack = (state_q == S_XFER) & bus.m_ack;
  end

  // state register
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // next-state and memory/cache strobes, decoded from the current state only
  always_comb begin
    state_d     = state_q;
    bus.m_req   = 1'b0;
    bus.m_we    = 1'b0;
    bus.m_addr  = '0;
    bus.m_wdata = '0;
    bus.ic_dv   = 1'b0;
    bus.dc_dv   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (grant) state_d = S_XFER;
      end
      S_XFER: begin
        bus.m_req   = 1'b1;
        bus.m_we    = we_q;
        bus.m_addr  = {addr_q, cnt_q, 3'b000};
        bus.m_wdata = line_q[int'(cnt_q) * BEAT_W +: BEAT_W];
        if (bus.m_ack && (int'(cnt_q) == BEATS - 1)) state_d = S_DONE;
      end
      S_DONE: begin
        bus.ic_dv = (owner_q == OWN_IC);
        bus.dc_dv = (owner_q == OWN_DC);
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // both caches see the line buffer; only the owner's dv qualifies it
  always_comb begin
    bus.ic_data = line_q;
    bus.dc_data = line_q;
  end

  // transaction context latched on grant, beat counter and line buffer per ack
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      cnt_q   <= '0;
      line_q  <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      owner_q <= OWN_IC;
      last_q  <= OWN_DC;
    end else if (grant) begin
      cnt_q   <= '0;
      addr_q  <= win_dc ? bus.dc_addr[ADDR_W-1:7] : bus.ic_addr[ADDR_W-1:7];
      we_q    <= win_we;
      owner_q <= win_dc;
      last_q  <= win_dc;
      if (win_we) line_q <= bus.dc_wdata;
    end else if (beat_ack) begin
      cnt_q <= cnt_q + 4'd1;   // wraps to 0 after the last beat of the line
      if (!we_q) line_q[int'(cnt_q) * BEAT_W +: BEAT_W] <= bus.m_rdata;
    end
  end

endmodule

// File: tb/tb_line_bus_ctrl.sv
// Directed bench for line_bus_ctrl: fills, write-back, arbitration,
// async reset mid-burst and a long memory stall.
module tb_line_bus_ctrl;

  localparam int ADDR_W = 64;
  localparam int LINE_W = 1024;
  localparam int BEAT_W = 64;

  logic clk;
  logic clr_n;
  int   checks;
  int   errors;
  logic [63:0] wexp [16];

  line_bus_ctrl_if #(.ADDR_W(ADDR_W), .LINE_W(LINE_W), .BEAT_W(BEAT_W)) bus ();

  line_bus_ctrl #(.ADDR_W(ADDR_W), .LINE_W(LINE_W), .BEAT_W(BEAT_W)) dut (
    .clk   (clk),
    .clr_n (clr_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Runs one burst. Caller has just raised the request at a negedge (k=0).
  // mode 0: ack every cycle, 1: ack every other cycle, 2: 50-cycle stall at beat 3.
  task automatic burst(input bit owner_dc, input bit we, input logic [63:0] base,
                       input int mode, input int exp_cyc, input logic [63:0] dbase);
    int beat;
    int stall;
    bit ack;
    bit done;
    beat  = 0;
    stall = 50;
    done  = 1'b0;
    for (int k = 1; k < 300 && !done; k++) begin
      @(negedge clk);
      if (beat < 16) begin
        check_val("m_req_burst", 64'(bus.m_req), 64'd1);
        check_val("m_we", 64'(bus.m_we), 64'(we));
        check_val("m_addr", bus.m_addr, base + 64'(beat) * 64'd8);
        if (we) check_val("m_wdata", bus.m_wdata, wexp[beat]);
        check_val("dv_early", 64'({bus.ic_dv, bus.dc_dv}), 64'd0);
        case (mode)
          1: ack = (k % 2 == 0);
          2: begin
            ack = !(beat == 3 && stall > 0);
            if (!ack) stall--;
          end
          default: ack = 1'b1;
        endcase
        bus.m_ack   = ack;
        bus.m_rdata = dbase + 64'(beat);
        if (ack) beat++;
      end else begin
        bus.m_ack = 1'b0;
        check_val("m_req_done", 64'(bus.m_req), 64'd0);
        check_val("ic_dv", 64'(bus.ic_dv), 64'(!owner_dc));
        check_val("dc_dv", 64'(bus.dc_dv), 64'(owner_dc));
        if (exp_cyc != 0) check_val("dv_cycle", 64'(k + 1), 64'(exp_cyc));
        if (!owner_dc)  bus.ic_rd = 1'b0;
        else if (we)    bus.dc_wr = 1'b0;
        else            bus.dc_rd = 1'b0;
        $display("burst owner=%s we=%0d base=%h done at cycle %0d",
                 owner_dc ? "DC" : "IC", we, base, k + 1);
        done = 1'b1;
      end
    end
    if (!done) check_val("burst_timeout", 64'd0, 64'd1);
    @(negedge clk);
    check_val("idle_gap_req", 64'(bus.m_req), 64'd0);
    check_val("idle_gap_dv", 64'({bus.ic_dv, bus.dc_dv}), 64'd0);
  endtask

  task automatic check_line(input string tag, input bit dc, input logic [63:0] dbase);
    for (int i = 0; i < 16; i++)
      check_val(tag, dc ? bus.dc_data[i*64 +: 64] : bus.ic_data[i*64 +: 64], dbase + 64'(i));
  endtask

  task automatic do_reset();
    @(negedge clk);
    clr_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    clr_n = 1'b1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    clr_n = 1'b0;
    bus.ic_rd = 0; bus.ic_addr = '0; bus.dc_rd = 0; bus.dc_wr = 0;
    bus.dc_addr = '0; bus.dc_wdata = '0; bus.m_rdata = '0; bus.m_ack = 0;

    // reset state
    repeat (2) @(negedge clk);
    check_val("rst_m_req", 64'(bus.m_req), 64'd0);
    check_val("rst_m_addr", bus.m_addr, 64'd0);
    check_val("rst_dv", 64'({bus.ic_dv, bus.dc_dv}), 64'd0);
    check_val("rst_ic_data", bus.ic_data[63:0], 64'd0);
    check_val("rst_dc_data", bus.dc_data[1023:960], 64'd0);
    clr_n = 1'b1;

    // icache fill, ack tied high, dv in cycle 18
    @(negedge clk);
    bus.ic_rd = 1'b1; bus.ic_addr = 64'h8000_0040;
    burst(1'b0, 1'b0, 64'h8000_0000, 0, 18, 64'd0);
    check_line("ic_fill_data", 1'b0, 64'd0);

    // dcache write-back, ack every other cycle
    for (int i = 0; i < 16; i++) begin
      wexp[i] = 64'hA0 + 64'(i);
      bus.dc_wdata[i*64 +: 64] = wexp[i];
    end
    bus.dc_wr = 1'b1; bus.dc_addr = 64'h1000;
    burst(1'b1, 1'b1, 64'h1000, 1, 0, 64'd0);

    // both caches from reset: IC first, then DC
    do_reset();
    bus.ic_rd = 1'b1; bus.ic_addr = 64'h3000;
    bus.dc_rd = 1'b1; bus.dc_addr = 64'h4000;
    burst(1'b0, 1'b0, 64'h3000, 0, 18, 64'h100);
    check_line("arb_ic_data", 1'b0, 64'h100);
    burst(1'b1, 1'b0, 64'h4000, 0, 18, 64'h200);
    check_line("arb_dc_data", 1'b1, 64'h200);

    // dcache read and write together: write-back first, then fill
    for (int i = 0; i < 16; i++) begin
      wexp[i] = 64'hB0 + 64'(i);
      bus.dc_wdata[i*64 +: 64] = wexp[i];
    end
    bus.dc_rd = 1'b1; bus.dc_wr = 1'b1; bus.dc_addr = 64'h2000;
    burst(1'b1, 1'b1, 64'h2000, 0, 18, 64'd0);
    burst(1'b1, 1'b0, 64'h2000, 0, 18, 64'h300);
    check_line("rw_dc_data", 1'b1, 64'h300);

    // async reset at beat 7 of an icache fill, then restart from beat 0
    bus.ic_rd = 1'b1; bus.ic_addr = 64'h6000;
    bus.m_ack = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      bus.m_rdata = 64'h500 + 64'(k - 1);
    end
    check_val("pre_rst_addr", bus.m_addr, 64'h6038);
    #2 clr_n = 1'b0;
    #1;
    check_val("async_rst_req", 64'(bus.m_req), 64'd0);
    check_val("async_rst_addr", bus.m_addr, 64'd0);
    check_val("async_rst_dv", 64'({bus.ic_dv, bus.dc_dv}), 64'd0);
    check_val("async_rst_line", bus.ic_data[63:0], 64'd0);
    bus.m_ack = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_val("rst_hold_dv", 64'(bus.ic_dv), 64'd0);
    clr_n = 1'b1;
    burst(1'b0, 1'b0, 64'h6000, 0, 18, 64'h600);
    check_line("restart_data", 1'b0, 64'h600);

    // 50-cycle memory stall at beat 3
    bus.ic_rd = 1'b1; bus.ic_addr = 64'h5000;
    burst(1'b0, 1'b0, 64'h5000, 2, 68, 64'h400);
    check_line("stall_data", 1'b0, 64'h400);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
